video_timing_240p: RTL and testbench

- Downstream consumer of the 25.6 MHz PLL output and its locked flag.
- Qualifies PLL lock, then generates a 240p (15.76 kHz / 60.16 Hz) raster: pixel clock-enable, counters, sync, blank and data-enable.
- Feeds the pattern generators and the video output stage.
- Runs entirely in the PLL output clock domain.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_timing_240p_if.sv | 24 ++
 rtl/lock_qualifier.sv | 80 ++++++++
 rtl/video_timing_240p.sv | 138 +++++++++++++
 tb/tb_video_timing_240p.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the 240p timing generator: default raster, counter widths, FSM encodings.
package video_timing_pkg;

  localparam int unsigned HCNT_W = 10;
  localparam int unsigned VCNT_W = 9;
  localparam int unsigned DIV_W  = 4;

  localparam int unsigned DEF_CE_DIV    = 4;
  localparam int unsigned DEF_H_ACTIVE  = 320;
  localparam int unsigned DEF_H_FP      = 14;
  localparam int unsigned DEF_H_SYNC    = 30;
  localparam int unsigned DEF_H_BP      = 42;
  localparam int unsigned DEF_V_ACTIVE  = 240;
  localparam int unsigned DEF_V_FP      = 3;
  localparam int unsigned DEF_V_SYNC    = 3;
  localparam int unsigned DEF_V_BP      = 16;
  localparam int unsigned DEF_LOCK_WAIT = 1024;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

endpackage

// File: rtl/video_timing_240p_if.sv
// Raster output bundle driven by the timing generator towards pattern/video stages.
interface video_timing_240p_if;
  import video_timing_pkg::*;

  logic              ce_pix;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblank;
  logic              vblank;
  logic              de;
  logic              frame_start;
  logic              running;

  modport master (
    output ce_pix, hcount, vcount, hsync, vsync, hblank, vblank, de, frame_start, running
  );

  modport slave (
    input ce_pix, hcount, vcount, hsync, vsync, hblank, vblank, de, frame_start, running
  );

endinterface

// File: rtl/lock_qualifier.sv
// Synchronises the PLL lock flag and demands LOCK_WAIT consecutive locked clocks before RUN.
module lock_qualifier
  import video_timing_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked_i,
  output logic running_o,
  output logic run_next_c
);

  localparam int unsigned LCNT_W = $clog2(LOCK_WAIT);

  if (LOCK_WAIT < 2) begin : g_lock_wait_chk
    $error("LOCK_WAIT must be at least 2");
  end

  logic              sync1_q;
  logic              lk_q;
  logic [1:0]        state_q, state_d;
  logic [LCNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked_i;
      lk_q    <= sync1_q;
    end
  end

  // Next-state logic: any lock drop restarts qualification from zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_q) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LCNT_W'(1);
          if (cnt_d == LCNT_W'(LOCK_WAIT - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lk_q) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State and lock counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign running_o  = (state_q == ST_RUN);
  // Lets the raster registers load their first RUN values on the same edge the FSM enters RUN
  assign run_next_c = ~rst & (state_d == ST_RUN);

endmodule

// File: rtl/video_timing_240p.sv
// 240p raster generator: pixel enable divider, h/v counters and registered sync/blank/de decodes.
module video_timing_240p
  import video_timing_pkg::*;
#(
  parameter int unsigned CE_DIV    = DEF_CE_DIV,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  video_timing_240p_if.master   vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > (1 << HCNT_W)) begin : g_h_chk
    $error("H_TOTAL does not fit the hcount width");
  end
  if (V_TOTAL > (1 << VCNT_W)) begin : g_v_chk
    $error("V_TOTAL does not fit the vcount width");
  end
  if (CE_DIV < 2 || CE_DIV > 16) begin : g_ce_chk
    $error("CE_DIV must be within 2..16");
  end

  logic running;
  logic run_next_c;

  lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock (
    .clk          (clk),
    .rst          (rst),
    .pll_locked_i (pll_locked),
    .running_o    (running),
    .run_next_c   (run_next_c)
  );

  logic [DIV_W-1:0]  div_q, div_d;
  logic              ce_q, ce_d;
  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblank_q, hblank_d;
  logic              vblank_q, vblank_d;
  logic              de_q, de_d;
  logic              fs_q, fs_d;

  // Next raster position and its decodes; everything collapses to the blanked set outside RUN
  always_comb begin
    div_d    = '0;
    h_d      = '0;
    v_d      = '0;
    ce_d     = 1'b0;
    hsync_d  = 1'b0;
    vsync_d  = 1'b0;
    hblank_d = 1'b1;
    vblank_d = 1'b1;
    de_d     = 1'b0;
    fs_d     = 1'b0;
    if (run_next_c) begin
      // First RUN clock keeps the zeroed defaults so the frame opens at (0,0) with ce_pix
      if (running) begin
        div_d = (div_q == DIV_W'(CE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (div_d == '0) begin
          if (h_q == HCNT_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VCNT_W'(V_TOTAL - 1)) ? '0 : v_q + VCNT_W'(1);
          end else begin
            h_d = h_q + HCNT_W'(1);
          end
        end
      end
      ce_d     = (div_d == '0);
      hsync_d  = (32'(h_d) >= HS_START) && (32'(h_d) < HS_END);
      vsync_d  = (32'(v_d) >= VS_START) && (32'(v_d) < VS_END);
      hblank_d = (32'(h_d) >= H_ACTIVE);
      vblank_d = (32'(v_d) >= V_ACTIVE);
      de_d     = ~hblank_d & ~vblank_d;
      fs_d     = ce_d && (h_d == '0) && (v_d == '0);
    end
  end

  // Raster registers; decodes share the counters' edge so nothing is skewed
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      ce_q     <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      ce_q     <= ce_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
    end
  end

  assign vid.ce_pix      = ce_q;
  assign vid.hcount      = h_q;
  assign vid.vcount      = v_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.hblank      = hblank_q;
  assign vid.vblank      = vblank_q;
  assign vid.de          = de_q;
  assign vid.frame_start = fs_q;
  assign vid.running     = running;

endmodule

// File: tb/tb_video_timing_240p.sv
// Bench for video_timing_240p: raster model compared every clock plus directed timing checks.
module tb_video_timing_240p;

  localparam int CE_DIV    = 4;
  localparam int H_ACTIVE  = 320;
  localparam int H_FP      = 14;
  localparam int H_SYNC    = 30;
  localparam int H_BP      = 42;
  localparam int V_ACTIVE  = 3;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam int LOCK_WAIT = 1024;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE      = 1624;
  localparam int FRAME     = 11368;

  localparam logic [26:0] RST_VEC = {1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;

  video_timing_240p_if vid ();

  video_timing_240p #(
    .CE_DIV    (CE_DIV),
    .H_ACTIVE  (H_ACTIVE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_ACTIVE  (V_ACTIVE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .LOCK_WAIT (LOCK_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .vid        (vid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  function automatic logic [26:0] dut_vec();
    return {vid.ce_pix, vid.hcount, vid.vcount, vid.hsync, vid.vsync,
            vid.hblank, vid.vblank, vid.de, vid.frame_start, vid.running};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: lock seen 2 clocks late; RUN holds once LOCK_WAIT consecutive locked clocks were seen
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_run = 1'b0;
  int m_streak = 0;
  int m_t = 0;

  always @(posedge clk) begin
    bit lk_seen;
    if (rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_streak = 0;
      m_run = 1'b0;
    end else begin
      lk_seen = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      m_streak = lk_seen ? m_streak + 1 : 0;
      if (m_streak >= LOCK_WAIT) begin
        m_t = m_run ? m_t + 1 : 0;
        m_run = 1'b1;
      end else begin
        m_run = 1'b0;
      end
    end
  end

  function automatic logic [26:0] model_vec();
    int px, h, v;
    logic ce, hs, vs, hb, vb;
    if (!m_run) return RST_VEC;
    px = m_t / CE_DIV;
    h  = px % H_TOTAL;
    v  = (px / H_TOTAL) % V_TOTAL;
    ce = (m_t % CE_DIV) == 0;
    hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    hb = h >= H_ACTIVE;
    vb = v >= V_ACTIVE;
    return {ce, 10'(h), 9'(v), hs, vs, hb, vb, ~hb & ~vb,
            ce && h == 0 && v == 0, 1'b1};
  endfunction

  // Every-clock comparison against the model
  always @(negedge clk) begin
    logic [26:0] a, e;
    if (cmp_en) begin
      a = dut_vec();
      e = model_vec();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t dut{ce,h,v,hs,vs,hb,vb,de,fs,run}=%0b,%0d,%0d,%0b%0b%0b%0b%0b%0b%0b model=%0b,%0d,%0d,%0b%0b%0b%0b%0b%0b%0b",
                 $time, a[26], a[25:16], a[15:7], a[6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e[26], e[25:16], e[15:7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    int n;
    int ce_last, ce_bad, hs_hi, de_l0, de_l2, de_l3, hs_rise_h;
    int vs_min, vs_max, vb_min, v_max, wraps, prev_v;
    bit prev_hs;
    int hs_rise[$];
    int fs_t[$];

    rst = 1'b1;
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_outputs", int'(dut_vec()), int'(RST_VEC));

    // Lock qualification from reset release
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!vid.running && n < 5000);
    chk("lock_latency", n, 2 + LOCK_WAIT);
    chk("first_ce", int'(vid.ce_pix), 1);
    chk("first_fs", int'(vid.frame_start), 1);
    chk("first_hcount", int'(vid.hcount), 0);
    chk("first_vcount", int'(vid.vcount), 0);

    // Two frames of free-running raster
    ce_last = -1; ce_bad = 0; hs_hi = 0; de_l0 = 0; de_l2 = 0; de_l3 = 0; hs_rise_h = -1;
    vs_min = 999; vs_max = -1; vb_min = 999; v_max = -1; wraps = 0;
    prev_hs = 1'b0; prev_v = int'(vid.vcount);
    for (int c = 0; c < 2 * FRAME + 8; c++) begin
      if (vid.ce_pix) begin
        if (ce_last >= 0 && c - ce_last != CE_DIV) ce_bad++;
        ce_last = c;
      end
      if (vid.hsync && !prev_hs) begin
        if (hs_rise.size() == 0) hs_rise_h = int'(vid.hcount);
        hs_rise.push_back(c);
      end
      prev_hs = vid.hsync;
      if (c < LINE) begin
        hs_hi += int'(vid.hsync);
        de_l0 += int'(vid.de);
      end else if (c >= 2 * LINE && c < 3 * LINE) de_l2 += int'(vid.de);
      else if (c >= 3 * LINE && c < 4 * LINE) de_l3 += int'(vid.de);
      if (vid.frame_start) fs_t.push_back(c);
      if (vid.vsync) begin
        if (int'(vid.vcount) < vs_min) vs_min = int'(vid.vcount);
        if (int'(vid.vcount) > vs_max) vs_max = int'(vid.vcount);
      end
      if (vid.vblank && int'(vid.vcount) < vb_min) vb_min = int'(vid.vcount);
      if (int'(vid.vcount) > v_max) v_max = int'(vid.vcount);
      if (prev_v == V_TOTAL - 1 && vid.vcount == 9'd0) wraps++;
      prev_v = int'(vid.vcount);
      @(negedge clk);
    end
    chk("ce_period_errs", ce_bad, 0);
    chk("hs_rise_gap", (hs_rise.size() >= 2) ? hs_rise[1] - hs_rise[0] : -1, LINE);
    chk("hs_rise_hcount", hs_rise_h, 334);
    chk("hs_width", hs_hi, 120);
    chk("de_line0", de_l0, 1280);
    chk("de_line2", de_l2, 1280);
    chk("de_line3", de_l3, 0);
    chk("fs_count", fs_t.size(), 3);
    chk("fs_gap", (fs_t.size() >= 2) ? fs_t[1] - fs_t[0] : -1, FRAME);
    chk("fs_gap2", (fs_t.size() >= 3) ? fs_t[2] - fs_t[1] : -1, FRAME);
    chk("vsync_first_line", vs_min, 4);
    chk("vsync_last_line", vs_max, 5);
    chk("vblank_first_line", vb_min, 3);
    chk("vcount_max", v_max, 6);
    chk("vcount_wraps", wraps, 2);

    // Lock loss mid-frame, then relock
    n = 0;
    while (!(vid.hcount == 10'd100 && vid.vcount == 9'd2 && vid.ce_pix) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("reach_mid_frame", int'(vid.hcount == 10'd100 && vid.vcount == 9'd2), 1);
    pll_locked = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) pll_locked = 1'b1;
      if (n == 2) chk("still_running_n2", int'(vid.running), 1);
      if (n == 3) chk("loss_outputs", int'(dut_vec()), int'(RST_VEC));
    end while ((n < 3 || !vid.running) && n < 5000);
    chk("relock_latency", n, 3 + LOCK_WAIT);
    chk("relock_fs", int'(vid.frame_start), 1);
    chk("relock_origin", int'({vid.hcount, vid.vcount}), 0);

    // Lock glitch while settling at count 500
    pll_locked = 1'b0;
    repeat (10) @(negedge clk);
    chk("dropped_idle", int'(vid.running), 0);
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 501) pll_locked = 1'b0;
      if (n == 502) pll_locked = 1'b1;
    end while (!vid.running && n < 5000);
    chk("settle_glitch_latency", n, 1528);

    // Reset on the last pixel of the frame
    n = 0;
    while (!(vid.hcount == 10'd405 && vid.vcount == 9'd6 && vid.ce_pix) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("reach_last_pixel", int'(vid.hcount == 10'd405 && vid.vcount == 9'd6), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_last_pixel_outputs", int'(dut_vec()), int'(RST_VEC));
    chk("rst_last_pixel_fs", int'(vid.frame_start), 0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!vid.running && n < 5000);
    chk("rst_requalify_latency", n, 2 + LOCK_WAIT);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
